lcd_cmd_seq: RTL and testbench
==============================

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, command FIFO entries; power of two, 2..16.
REQ-002 Parameter GUARD_CYCLES, default 1, idle cycles after each issue before busy is re-sampled; range 1..3.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 host_cmd  input  3  command opcode from host (lcd_cmd_e encoding).
REQ-006 host_valid  input  1  host_cmd valid.
REQ-007 host_ready  output  1  FIFO can accept; transfer when host_valid && host_ready.
REQ-008 cmd  output  3  opcode to LCD controller.
REQ-009 cmd_valid  output  1  single-cycle issue strobe to LCD controller.
REQ-010 busy  input  1  LCD controller busy; no issue while high.
REQ-011 done  input  1  LCD controller image-loaded flag.
REQ-012 fifo_cnt  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 seq_idle  output  1  high when FIFO empty and FSM in IDLE.
REQ-014 stat_issued  output  16  commands issued (see Configuration).
REQ-015 stat_stall  output  16  cycles head-of-FIFO blocked by busy (see Configuration).

Function
REQ-016 host_ready SHALL equal (fifo_cnt < FIFO_DEPTH); write to a full FIFO SHALL never occur.
REQ-017 Simultaneous push and pop SHALL leave fifo_cnt unchanged, including when full or when going from 1 to 1.
REQ-018 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 FSM states: IDLE, ISSUE, GUARD.
REQ-020 IDLE -> ISSUE when fifo_cnt != 0 and busy == 0 and done == 1.
REQ-021 In ISSUE, cmd SHALL drive the FIFO head, cmd_valid SHALL be 1 for exactly that cycle, and the head SHALL pop; the next state is GUARD.
REQ-022 GUARD SHALL hold cmd_valid at 0 for GUARD_CYCLES cycles, then return to IDLE.
REQ-023 Opcode WRITE (0) SHALL additionally block IDLE -> ISSUE until done has been observed 0 and then 1 again after the issue (reload fence).
REQ-024 Minimum issue spacing SHALL be 1 + GUARD_CYCLES cycles; cmd_valid SHALL never be high in two consecutive cycles.
REQ-025 cmd SHALL hold its last issued value while cmd_valid is 0.
REQ-026 Opcodes 1..7 SHALL pass unmodified; the block performs no coordinate tracking.
REQ-027 seq_idle SHALL be combinational from fifo_cnt == 0 and state == IDLE.

Reset
REQ-028 Reset SHALL force state IDLE, both pointers 0, fifo_cnt 0, cmd 0, cmd_valid 0, the WRITE fence cleared, and both stat counters 0.
REQ-029 Reset asserted mid-ISSUE or mid-GUARD SHALL discard all queued commands; no cmd_valid pulse SHALL be generated in the first cycle after reset deasserts.
REQ-030 FIFO storage SHALL not be reset; contents are don't-care while empty.

Configuration
REQ-031 Macro LCD_CMD_STATS_EN: when defined, stat_issued SHALL increment on each cmd_valid, and stat_stall SHALL increment each cycle that fifo_cnt != 0, state == IDLE and busy == 1.
REQ-032 Both counters SHALL saturate at 16'hFFFF.
REQ-033 Without LCD_CMD_STATS_EN, stat_issued and stat_stall SHALL be constant 0, with no counter flops.

Structure
REQ-034 Package lcd_pkg SHALL hold lcd_cmd_e (WRITE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, AVG=5, MX=6, MY=7) and the 3-bit-field coordinate_s struct, shared with the LCD controller.
REQ-035 The FIFO SHALL be the sub-module lcd_cmd_fifo (parameter DEPTH, width 3, push/pop/full/empty/count); the FSM and counters live in lcd_cmd_seq.

Verification
REQ-036 Scenario: reset; done=1, busy=0; push RIGHT, DOWN, AVG -> cmd_valid pulses with cmd 4, 2, 5 spaced exactly 2 cycles apart (GUARD_CYCLES=1).
REQ-037 Scenario: push 9 commands with no issue (busy=1) -> host_ready=0 after the 8th push, fifo_cnt=8; releasing busy drains all 8 in order.
REQ-038 Scenario: push WRITE, UP; done falls 2 cycles after issue and rises 70 cycles later -> UP is issued no earlier than 1 cycle after done rises.
REQ-039 Scenario: assert reset while in GUARD with 3 entries queued -> fifo_cnt=0, cmd_valid=0, seq_idle=1 after reset.
REQ-040 Scenario: with LCD_CMD_STATS_EN, hold busy=1 for 5 cycles with 1 entry queued, then release -> stat_stall=5, stat_issued=1; without the macro both read 0.
REQ-041 Scenario: push on the same cycle as a pop at fifo_cnt=8 -> fifo_cnt stays 8 and order is preserved.

Source files
------------

// File: rtl/lcd_pkg.sv
// Types shared between the LCD command sequencer and the LCD controller.
// Includes the opcode enum, the coordinate struct and the sequencer-internal encodings.
package lcd_pkg;

   localparam int CMD_W = 3;
   localparam int CNT_W = 5;

   typedef enum logic [2:0] {
      WRITE = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4,
      AVG   = 3'd5,
      MX    = 3'd6,
      MY    = 3'd7
   } lcd_cmd_e;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
   } coordinate_s;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GUARD = 2'd2
   } seq_state_e;

   // Reload fence after a WRITE: wait for done to fall, then to rise again.
   typedef enum logic [1:0] {
      FENCE_NONE      = 2'd0,
      FENCE_WAIT_LOW  = 2'd1,
      FENCE_WAIT_HIGH = 2'd2
   } fence_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO for the LCD sequencer: DEPTH entries of 3 bits, power-of-two depth.
// Storage is not reset; only pointers and occupancy are.
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] wdata,
   output logic [CMD_W-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en, rd_en;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host opcodes and issues them one at a time to the LCD controller.
// Optional statistics counters are built when LCD_CMD_STATS_EN is defined.
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int GUARD_CYCLES = 1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CMD_W-1:0] host_cmd,
   input  logic             host_valid,
   output logic             host_ready,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_valid,
   input  logic             busy,
   input  logic             done,
   output logic [CNT_W-1:0] fifo_cnt,
   output logic             seq_idle,
   output logic [15:0]      stat_issued,
   output logic [15:0]      stat_stall
);

   localparam logic [1:0] GUARD_LAST = 2'(GUARD_CYCLES - 1);

   seq_state_e       state_q, state_d;
   fence_e           fence_q, fence_d;
   logic [1:0]       guard_q, guard_d;
   logic [CMD_W-1:0] last_cmd_q, last_cmd_d;
   logic [CMD_W-1:0] head;
   logic             fifo_full, fifo_empty;
   logic             push, pop, can_issue;

   assign host_ready = !fifo_full;
   assign push       = host_valid && host_ready;
   assign pop        = (state_q == ST_ISSUE);
   assign seq_idle   = fifo_empty && (state_q == ST_IDLE);
   assign can_issue  = !fifo_empty && !busy && done && (fence_q == FENCE_NONE);

   lcd_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (host_cmd),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   always_comb begin
      state_d    = state_q;
      fence_d    = fence_q;
      guard_d    = guard_q;
      last_cmd_d = last_cmd_q;
      cmd_valid  = 1'b0;
      cmd        = last_cmd_q;

      case (fence_q)
         FENCE_WAIT_LOW:  if (!done) fence_d = FENCE_WAIT_HIGH;
         FENCE_WAIT_HIGH: if (done)  fence_d = FENCE_NONE;
         default:         fence_d = fence_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (can_issue) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            cmd_valid  = 1'b1;
            cmd        = head;
            last_cmd_d = head;
            guard_d    = '0;
            state_d    = ST_GUARD;
            if (lcd_cmd_e'(head) == WRITE) fence_d = FENCE_WAIT_LOW;
         end
         ST_GUARD: begin
            // The last guard cycle doubles as the busy re-sample point, giving 1+GUARD_CYCLES spacing.
            if (guard_q == GUARD_LAST) state_d = can_issue ? ST_ISSUE : ST_IDLE;
            else                       guard_d = guard_q + 2'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fence_q    <= FENCE_NONE;
         guard_q    <= '0;
         last_cmd_q <= '0;
      end else begin
         state_q    <= state_d;
         fence_q    <= fence_d;
         guard_q    <= guard_d;
         last_cmd_q <= last_cmd_d;
      end
   end

`ifdef LCD_CMD_STATS_EN
   logic [15:0] issued_q, issued_d;
   logic [15:0] stall_q, stall_d;

   always_comb begin
      issued_d = issued_q;
      stall_d  = stall_q;
      if (cmd_valid) issued_d = sat_inc16(issued_q);
      if (!fifo_empty && (state_q == ST_IDLE) && busy) stall_d = sat_inc16(stall_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign stat_issued = issued_q;
   assign stat_stall  = stall_q;
`else
   assign stat_issued = 16'd0;
   assign stat_stall  = 16'd0;
`endif

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq against a cycle-level behavioural reference model.
// Stat expectations follow LCD_CMD_STATS_EN when it is defined for the build.
module tb_lcd_cmd_seq;
   import lcd_pkg::*;

   localparam int DEPTH = 8;
   localparam int G     = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  host_cmd;
   logic        host_valid;
   logic        host_ready;
   logic [2:0]  cmd;
   logic        cmd_valid;
   logic        busy;
   logic        done;
   logic [4:0]  fifo_cnt;
   logic        seq_idle;
   logic [15:0] stat_issued;
   logic [15:0] stat_stall;

   lcd_cmd_seq #(
      .FIFO_DEPTH   (DEPTH),
      .GUARD_CYCLES (G)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .host_cmd    (host_cmd),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .busy        (busy),
      .done        (done),
      .fifo_cnt    (fifo_cnt),
      .seq_idle    (seq_idle),
      .stat_issued (stat_issued),
      .stat_stall  (stat_stall)
   );

   always #5 clk = ~clk;

   int n_cmp, n_err;

   // Reference model state: queue contents, issue history, fence observations, stats.
   int         cyc;
   logic [2:0] mq[$];
   int         last_issue;
   logic [2:0] m_last;
   bit         m_issue;
   bit         f_act, f_low, f_done;
   int         m_stall, m_issued;

   // Issues seen on the DUT outputs (cycle and opcode).
   int         dut_cyc[$];
   logic [2:0] dut_cmd[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic void model_reset();
      mq.delete();
      last_issue = -1000000;
      m_last     = 3'd0;
      m_issue    = 1'b0;
      f_act      = 1'b0;
      f_low      = 1'b0;
      f_done     = 1'b0;
      m_stall    = 0;
      m_issued   = 0;
   endfunction

   task automatic check_cycle();
      bit idle;
      idle = !m_issue && (cyc > last_issue + G);
      check("cmd_valid",  cmd_valid, m_issue);
      check("cmd",        cmd, m_issue ? mq[0] : m_last);
      check("fifo_cnt",   fifo_cnt, mq.size());
      check("host_ready", host_ready, mq.size() < DEPTH);
      check("seq_idle",   seq_idle, (mq.size() == 0) && idle);
`ifdef LCD_CMD_STATS_EN
      check("stat_issued", stat_issued, m_issued);
      check("stat_stall",  stat_stall, m_stall);
`else
      check("stat_issued", stat_issued, 0);
      check("stat_stall",  stat_stall, 0);
`endif
   endtask

   function automatic void model_advance(input bit v, input logic [2:0] c, input bit b, input bit d);
      bit idle, fclear, cond;
      int sz;
      idle   = !m_issue && (cyc > last_issue + G);
      sz     = mq.size();
      fclear = !f_act || f_done;
      cond   = (sz != 0) && !b && d && fclear;
      if (sz != 0 && idle && b) m_stall = sat16(m_stall);
      if (f_act && !f_done) begin
         if (!f_low) begin
            if (!d) f_low = 1'b1;
         end else if (d) begin
            f_done = 1'b1;
         end
      end
      if (m_issue) begin
         m_issued   = sat16(m_issued);
         last_issue = cyc;
         m_last     = mq.pop_front();
         if (m_last == WRITE) begin
            f_act  = 1'b1;
            f_low  = 1'b0;
            f_done = 1'b0;
         end
      end
      if (v && sz < DEPTH) mq.push_back(c);
      m_issue = cond && (cyc >= last_issue + G);
      cyc++;
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic cyc_step(input bit v, input logic [2:0] c, input bit b, input bit d);
      host_valid = v;
      host_cmd   = c;
      busy       = b;
      done       = d;
      #1;
      if (cmd_valid === 1'b1) begin
         dut_cyc.push_back(cyc);
         dut_cmd.push_back(cmd);
      end
      check_cycle();
      model_advance(v, c, b, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      host_valid = 1'b0;
      host_cmd   = 3'd0;
      busy       = 1'b0;
      done       = 1'b1;
      #1;
      check("rst_fifo_cnt",  fifo_cnt, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd",       cmd, 0);
      check("rst_seq_idle",  seq_idle, 1);
      check("rst_ready",     host_ready, 1);
      check("rst_issued",    stat_issued, 0);
      check("rst_stall",     stat_stall, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] r;
      logic [2:0] exp_q[$];
      int         w, up_cyc, k;
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      model_reset();
      do_reset();

      // Three back-to-back commands issue at minimum spacing
      dut_cyc.delete(); dut_cmd.delete();
      cyc_step(1, RIGHT, 0, 1);
      cyc_step(1, DOWN, 0, 1);
      cyc_step(1, AVG, 0, 1);
      repeat (8) cyc_step(0, 3'd0, 0, 1);
      check("s1_count", dut_cyc.size(), 3);
      if (dut_cyc.size() == 3) begin
         check("s1_cmd0", dut_cmd[0], 4);
         check("s1_cmd1", dut_cmd[1], 2);
         check("s1_cmd2", dut_cmd[2], 5);
         check("s1_gap0", dut_cyc[1] - dut_cyc[0], 2);
         check("s1_gap1", dut_cyc[2] - dut_cyc[1], 2);
      end

      // Fill with busy held, then drain in order
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         r = 3'($urandom_range(1, 7));
         if (i < DEPTH) exp_q.push_back(r);
         cyc_step(1, r, 1, 1);
      end
      check("s2_full_cnt",   fifo_cnt, 8);
      check("s2_full_ready", host_ready, 0);
      dut_cyc.delete(); dut_cmd.delete();
      repeat (24) cyc_step(0, 3'd0, 0, 1);
      check("s2_drained", dut_cmd.size(), 8);
      for (int i = 0; i < 8 && i < dut_cmd.size(); i++) check("s2_order", dut_cmd[i], exp_q[i]);

      // Host keeps pushing while the full FIFO starts draining
      for (int i = 0; i < DEPTH; i++) cyc_step(1, 3'($urandom_range(1, 7)), 1, 1);
      for (int i = 0; i < 6; i++) cyc_step(1, 3'($urandom_range(1, 7)), 0, 1);
      repeat (30) cyc_step(0, 3'd0, 0, 1);

      // WRITE reload fence
      dut_cyc.delete(); dut_cmd.delete();
      cyc_step(1, WRITE, 0, 1);
      cyc_step(1, UP, 0, 1);
      w = -1;
      for (int i = 0; i < 160; i++) begin
         if (w < 0 && m_issue) w = cyc;
         cyc_step(0, 3'd0, 0, !(w >= 0 && cyc >= w + 2 && cyc < w + 72));
      end
      check("s3_issues", dut_cmd.size(), 2);
      if (dut_cmd.size() == 2) begin
         up_cyc = dut_cyc[1];
         check("s3_first_write", dut_cmd[0], 0);
         check("s3_second_up",   dut_cmd[1], 1);
         check("s3_fence_hold",  (w >= 0) && (up_cyc >= w + 73), 1);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc_step($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
      end
      repeat (20) cyc_step(0, 3'd0, 0, 1);
      repeat (4) cyc_step(0, 3'd0, 0, 0);
      repeat (20) cyc_step(0, 3'd0, 0, 1);

      // Reset while in GUARD with three entries still queued
      for (int i = 0; i < 4; i++) cyc_step(1, 3'($urandom_range(1, 7)), 1, 1);
      k = 0;
      while (!(cyc == last_issue + 1 && mq.size() == 3) && k < 20) begin
         cyc_step(0, 3'd0, 0, 1);
         k++;
      end
      check("s4_reached_guard", k < 20, 1);
      do_reset();
      check("s4_cnt_after",  fifo_cnt, 0);
      check("s4_idle_after", seq_idle, 1);
      check("s4_vld_after",  cmd_valid, 0);
      repeat (3) cyc_step(0, 3'd0, 0, 1);

      // Stall and issue counters
      do_reset();
      cyc_step(1, UP, 1, 1);
      repeat (5) cyc_step(0, 3'd0, 1, 1);
      cyc_step(0, 3'd0, 0, 1);
      repeat (4) cyc_step(0, 3'd0, 0, 1);
`ifdef LCD_CMD_STATS_EN
      check("s5_stall",  stat_stall, 5);
      check("s5_issued", stat_issued, 1);
`else
      check("s5_stall",  stat_stall, 0);
      check("s5_issued", stat_issued, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
